// File: rtl/bias_stream_mc_pkg.sv
// Shared types for the bias streaming source: coefficient width, FSM encoding
// and a width helper that never returns zero.
package bias_stream_mc_pkg;

  localparam int COEFF_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bias_stream_mc_skid_buf.sv
// Two-entry FIFO that absorbs the ROM read latency; push and pop in the same
// cycle are legal at any occupancy.
module bias_stream_mc_skid_buf import bias_stream_mc_pkg::*; #(
  parameter int DATA_W = COEFF_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [1:0]        occ,
  output logic [DATA_W-1:0] dout
);

  logic [1:0]        occ_d, occ_q;
  logic [DATA_W-1:0] head_d, head_q;
  logic [DATA_W-1:0] tail_d, tail_q;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    case (occ_q)
      2'd0: begin
        if (push) begin
          head_d = din;
          occ_d  = 2'd1;
        end else begin
          occ_d  = 2'd0;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = din;
        end else if (push) begin
          tail_d = din;
          occ_d  = 2'd2;
        end else if (pop) begin
          occ_d  = 2'd0;
        end else begin
          occ_d  = 2'd1;
        end
      end
      2'd2: begin
        // A push while full is only possible together with a pop
        if (pop) begin
          head_d = tail_q;
          if (push) begin
            tail_d = din;
          end else begin
            occ_d  = 2'd1;
          end
        end else begin
          occ_d = 2'd2;
        end
      end
      default: begin
        occ_d = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  always_comb begin
    if (occ_q != 2'd0) begin
      dout = head_q;
    end else begin
      dout = '0;
    end
  end

  assign occ = occ_q;

endmodule

// File: rtl/rom.sv
// Registered-read coefficient ROM; q is valid the cycle after ce.
// Contents come from the packed INIT parameter, word 0 in the least significant bits.
module rom #(
  parameter int mem_size   = 64,
  parameter int data_width = 16,
  parameter int addr_width = 6,
  parameter logic [mem_size*data_width-1:0] INIT = '0
) (
  input  logic                  clk,
  input  logic                  ce,
  input  logic [addr_width-1:0] addr,
  output logic [data_width-1:0] q
);

  logic [data_width-1:0] rom_s [mem_size];
  logic [data_width-1:0] q_d;
  logic [data_width-1:0] q_q;

  for (genvar g = 0; g < mem_size; g++) begin : g_word
    assign rom_s[g] = INIT[g*data_width +: data_width];
  end

  always_comb begin
    q_d = q_q;
    if (ce) begin
      q_d = rom_s[addr];
    end else begin
      q_d = q_q;
    end
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/bias_stream_mc.sv
// Streams NUM_CH bias coefficients (LANES per word) from a ROM into a FIFO,
// REPEAT sweeps per ap_start (0 = forever), with lossless back-pressure.
module bias_stream_mc import bias_stream_mc_pkg::*; #(
  parameter int COEFF_W = COEFF_WIDTH,
  parameter int NUM_CH  = 64,
  parameter int LANES   = 1,
  parameter int REPEAT  = 1,
  parameter logic [NUM_CH*COEFF_W-1:0] MEM_INIT = '0
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic                     ap_start,
  output logic                     ap_idle,
  output logic                     ap_done,
  output logic [LANES*COEFF_W-1:0] output_V_din,
  input  logic                     output_V_full_n,
  output logic                     output_V_write
);

  localparam int DEPTH  = NUM_CH / LANES;
  localparam int DATA_W = LANES * COEFF_W;
  localparam int AW     = clog2_min1(DEPTH);
  localparam int SW     = clog2_min1(REPEAT + 1);
  localparam logic [AW-1:0] ADDR_LAST  = AW'(DEPTH - 1);
  localparam logic [SW-1:0] SWEEP_LAST = (REPEAT == 0) ? '0 : SW'(REPEAT - 1);
  localparam bit            FINITE     = (REPEAT != 0);

  state_e            state_d, state_q;
  logic [AW-1:0]     addr_d, addr_q;
  logic [SW-1:0]     sweep_d, sweep_q;
  logic              inflight_q;
  logic              rom_ce_s;
  logic              last_rd_s;
  logic              pop_s;
  logic [2:0]        pending_s;
  logic [1:0]        occ_s;
  logic [DATA_W-1:0] rom_q_s;
  logic [DATA_W-1:0] head_s;

  rom #(
    .mem_size   (DEPTH),
    .data_width (DATA_W),
    .addr_width (AW),
    .INIT       (MEM_INIT)
  ) u_rom (
    .clk  (ap_clk),
    .ce   (rom_ce_s),
    .addr (addr_q),
    .q    (rom_q_s)
  );

  bias_stream_mc_skid_buf #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk  (ap_clk),
    .rst  (ap_rst),
    .push (inflight_q),
    .din  (rom_q_s),
    .pop  (pop_s),
    .occ  (occ_s),
    .dout (head_s)
  );

  assign pop_s     = (occ_s != 2'd0) && output_V_full_n;
  assign last_rd_s = FINITE && (addr_q == ADDR_LAST) && (sweep_q == SWEEP_LAST);

  // Only issue when the word it returns is guaranteed a buffer slot
  always_comb begin
    pending_s = {1'b0, occ_s} + {2'b00, inflight_q} - {2'b00, pop_s};
    if ((state_q == ST_RUN) && (pending_s < 3'd2)) begin
      rom_ce_s = 1'b1;
    end else begin
      rom_ce_s = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sweep_d = sweep_q;
    case (state_q)
      ST_IDLE: begin
        if (ap_start) begin
          state_d = ST_RUN;
          addr_d  = '0;
          sweep_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (rom_ce_s && last_rd_s) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if ((occ_s == 2'd0) && !inflight_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (rom_ce_s) begin
      if (addr_q == ADDR_LAST) begin
        addr_d  = '0;
        sweep_d = sweep_q + SW'(1);
      end else begin
        addr_d  = addr_q + AW'(1);
      end
    end else begin
      addr_d = addr_d;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      sweep_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      sweep_q    <= sweep_d;
      inflight_q <= rom_ce_s;
    end
  end

  assign ap_idle        = (state_q == ST_IDLE);
  assign ap_done        = (state_q == ST_DONE);
  assign output_V_write = pop_s;
  assign output_V_din   = head_s;

endmodule

// File: tb/tb_bias_stream_mc.sv
// Scoreboard bench: stimulus pushes expected words, per-instance monitors pop on every write.
module tb_bias_stream_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Instance A: NUM_CH=4, LANES=1, REPEAT=1
  logic        a_rst, a_start, a_full_n, a_idle, a_done, a_write;
  logic [15:0] a_din;
  logic [31:0] a_q[$];
  int a_wr, a_done_n, a_first, a_last, a_done_cyc;

  bias_stream_mc #(.COEFF_W(16), .NUM_CH(4), .LANES(1), .REPEAT(1),
                   .MEM_INIT(64'h0004_0003_0002_0001)) u_a (
    .ap_clk(clk), .ap_rst(a_rst), .ap_start(a_start), .ap_idle(a_idle), .ap_done(a_done),
    .output_V_din(a_din), .output_V_full_n(a_full_n), .output_V_write(a_write));

  // Instance B: NUM_CH=8, LANES=2, REPEAT=3
  logic        bc_rst, b_start, b_full_n, b_idle, b_done, b_write;
  logic [31:0] b_din;
  logic [31:0] b_q[$];
  int b_wr, b_done_n;

  bias_stream_mc #(.COEFF_W(16), .NUM_CH(8), .LANES(2), .REPEAT(3),
                   .MEM_INIT(128'h0008_0007_0006_0005_0004_0003_0002_0001)) u_b (
    .ap_clk(clk), .ap_rst(bc_rst), .ap_start(b_start), .ap_idle(b_idle), .ap_done(b_done),
    .output_V_din(b_din), .output_V_full_n(b_full_n), .output_V_write(b_write));

  // Instance C: NUM_CH=4, LANES=1, REPEAT=0 (endless)
  logic        c_start, c_full_n, c_idle, c_done, c_write;
  logic [15:0] c_din;
  logic [31:0] c_q[$];
  int c_wr, c_done_n;

  bias_stream_mc #(.COEFF_W(16), .NUM_CH(4), .LANES(1), .REPEAT(0),
                   .MEM_INIT(64'h0004_0003_0002_0001)) u_c (
    .ap_clk(clk), .ap_rst(bc_rst), .ap_start(c_start), .ap_idle(c_idle), .ap_done(c_done),
    .output_V_din(c_din), .output_V_full_n(c_full_n), .output_V_write(c_write));

  always @(negedge clk) begin
    if (a_write) begin
      check("a_write_gated_by_full_n", {63'd0, a_full_n}, 64'd1);
      if (a_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL a_extra_write: got din %0h expected no write", a_din);
      end else begin
        check("a_din", {48'd0, a_din}, {32'd0, a_q.pop_front()});
      end
      a_wr++;
      if (a_first < 0) a_first = cyc;
      a_last = cyc;
    end
    if (a_done) begin
      a_done_n++;
      a_done_cyc = cyc;
    end
  end

  always @(negedge clk) begin
    if (b_write) begin
      if (b_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL b_extra_write: got din %0h expected no write", b_din);
      end else begin
        check("b_din", {32'd0, b_din}, {32'd0, b_q.pop_front()});
      end
      b_wr++;
    end
    if (b_done) b_done_n++;
  end

  always @(negedge clk) begin
    if (c_write) begin
      if (c_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL c_extra_write: got din %0h expected no write", c_din);
      end else begin
        check("c_din", {48'd0, c_din}, {32'd0, c_q.pop_front()});
      end
      c_wr++;
    end
    if (c_done) c_done_n++;
  end

  task automatic a_clear();
    a_wr = 0; a_done_n = 0; a_first = -1; a_last = -1; a_done_cyc = -1;
  endtask

  task automatic a_push_sweep();
    for (int i = 1; i <= 4; i++) a_q.push_back(32'(i));
  endtask

  task automatic a_pulse_start();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  task automatic a_wait_done(input int bound);
    for (int i = 0; i < bound && a_done_n == 0; i++) tick();
  endtask

  initial begin
    int t0;
    a_rst = 1'b1; bc_rst = 1'b1;
    a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
    a_full_n = 1'b1; b_full_n = 1'b1; c_full_n = 1'b1;
    a_clear();
    b_wr = 0; b_done_n = 0; c_wr = 0; c_done_n = 0;
    tick(2);

    check("rst_a_idle",  {63'd0, a_idle},  64'd1);
    check("rst_a_done",  {63'd0, a_done},  64'd0);
    check("rst_a_write", {63'd0, a_write}, 64'd0);
    check("rst_a_din",   {48'd0, a_din},   64'd0);
    check("rst_b_idle",  {63'd0, b_idle},  64'd1);
    check("rst_b_din",   {32'd0, b_din},   64'd0);
    a_rst = 1'b0; bc_rst = 1'b0;
    tick();

    // Test 1: free-running sweep, first write 2 cycles after the start edge
    a_push_sweep();
    a_clear();
    t0 = cyc;
    a_pulse_start();
    a_wait_done(50);
    check("t1_writes",       64'(a_wr), 64'd4);
    check("t1_first_cycle",  64'(a_first), 64'(t0 + 3));
    check("t1_back_to_back", 64'(a_last - a_first), 64'd3);
    check("t1_done_count",   64'(a_done_n), 64'd1);
    check("t1_done_after",   {63'd0, a_done_cyc > a_last}, 64'd1);
    tick();
    check("t1_idle",         {63'd0, a_idle}, 64'd1);
    check("t1_queue_empty",  64'(a_q.size()), 64'd0);

    // Test 2: full_n toggled every cycle
    a_push_sweep();
    a_clear();
    a_pulse_start();
    for (int i = 0; i < 80 && a_done_n == 0; i++) begin
      a_full_n = ~a_full_n;
      tick();
    end
    a_full_n = 1'b1;
    tick(2);
    check("t2_writes",      64'(a_wr), 64'd4);
    check("t2_done_count",  64'(a_done_n), 64'd1);
    check("t2_queue_empty", 64'(a_q.size()), 64'd0);
    check("t2_idle",        {63'd0, a_idle}, 64'd1);

    // Test 5: reset after the 2nd write, then a clean restart
    a_push_sweep();
    a_clear();
    a_pulse_start();
    for (int i = 0; i < 50 && a_wr < 2; i++) tick();
    a_rst = 1'b1;
    #1;
    check("t5_rst_write", {63'd0, a_write}, 64'd0);
    check("t5_rst_din",   {48'd0, a_din},   64'd0);
    check("t5_rst_idle",  {63'd0, a_idle},  64'd1);
    check("t5_rst_done",  {63'd0, a_done},  64'd0);
    a_q.delete();
    tick(2);
    check("t5_writes_before_rst", 64'(a_wr), 64'd2);
    a_rst = 1'b0;
    tick();
    a_push_sweep();
    a_clear();
    a_pulse_start();
    a_wait_done(50);
    tick(2);
    check("t5_restart_writes", 64'(a_wr), 64'd4);
    check("t5_restart_done",   64'(a_done_n), 64'd1);
    check("t5_queue_empty",    64'(a_q.size()), 64'd0);

    // Test 6: held full, start re-pulsed while running, then released
    a_push_sweep();
    a_clear();
    a_full_n = 1'b0;
    a_pulse_start();
    tick(4);
    a_pulse_start();
    tick(4);
    check("t6_no_write_stalled", 64'(a_wr), 64'd0);
    check("t6_busy_stalled",     {63'd0, a_idle}, 64'd0);
    a_full_n = 1'b1;
    a_wait_done(50);
    tick(10);
    check("t6_writes",       64'(a_wr), 64'd4);
    check("t6_back_to_back", 64'(a_last - a_first), 64'd3);
    check("t6_done_count",   64'(a_done_n), 64'd1);
    check("t6_idle",         {63'd0, a_idle}, 64'd1);
    check("t6_queue_empty",  64'(a_q.size()), 64'd0);

    // Test 3: two lanes, three sweeps
    for (int s = 0; s < 3; s++)
      for (int w = 0; w < 4; w++)
        b_q.push_back({16'(2 * w + 2), 16'(2 * w + 1)});
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int i = 0; i < 200 && b_done_n == 0; i++) tick();
    tick(3);
    check("t3_writes",      64'(b_wr), 64'd12);
    check("t3_done_count",  64'(b_done_n), 64'd1);
    check("t3_queue_empty", 64'(b_q.size()), 64'd0);
    check("t3_idle",        {63'd0, b_idle}, 64'd1);

    // Test 4: endless sweep wraps 1..4 and never completes
    for (int i = 0; i < 40; i++) c_q.push_back(32'((i % 4) + 1));
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    tick(20);
    c_full_n = 1'b0;
    tick(2);
    check("t4_stream_len",  {63'd0, c_wr >= 15}, 64'd1);
    check("t4_never_done",  64'(c_done_n), 64'd0);
    check("t4_still_busy",  {63'd0, c_idle}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
